// File: rtl/controlador_varredura.sv
// controlador_varredura: 4-digit multiplexed BCD display scanner with guard cycles and frame-synchronous loads
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit0 always shown).
module controlador_varredura #(
   parameter int DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] din,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   output logic [3:0]  an,
   output logic        frame_done
);
   typedef enum logic [2:0] {DIG0 = 3'd0, DIG1 = 3'd1, DIG2 = 3'd2, DIG3 = 3'd3, IDLE = 3'd4} st_t;
   st_t state, nxt_state;
   logic [15:0] cnt, nxt_cnt, act, nxt_act, pend;
   logic pflag, entering, blank, lz;
   logic [1:0] n;
   logic [3:0] dig;
   // next state/slot and the digits that will be active after this edge; outputs are registered from these
   always_comb begin
      nxt_state = state;
      nxt_cnt = 16'd0;
      if (state == IDLE) nxt_state = en ? DIG0 : IDLE;
      else if (!en) nxt_state = IDLE;
      else if (cnt == 16'(DIV - 1)) nxt_state = st_t'({1'b0, state[1:0] + 2'd1});
      else nxt_cnt = cnt + 16'd1;
      entering = (nxt_state == DIG0) && (state != DIG0);
      nxt_act = (entering && load) ? din : (entering && pflag) ? pend : act;
   end
   assign n = nxt_state[1:0];
   assign dig = nxt_act[{n, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
   assign lz = (n != 2'd0) && ((nxt_act >> {n, 2'b00}) == 16'h0000);
`else
   assign lz = 1'b0;
`endif
   assign blank = (dig > 4'd9) || lz;
   // state, slot counter, digit registers and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= 16'd0;
         act <= 16'h0000;
         pend <= 16'h0000;
         pflag <= 1'b0;
         {A, B, C, D} <= 4'h0;
         an <= 4'hF;
         frame_done <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt <= nxt_cnt;
         act <= nxt_act;
         if (entering) pflag <= 1'b0;
         else if (load) begin
            pend <= din;
            pflag <= 1'b1;
         end
         {A, B, C, D} <= (nxt_state == IDLE) ? 4'h0 : dig;
         an <= (nxt_state == IDLE || nxt_cnt == 16'd0 || blank) ? 4'hF : ~(4'b0001 << n);
         frame_done <= (nxt_state == DIG3) && (nxt_cnt == 16'(DIV - 1));
      end
   end
endmodule

// File: doc/controlador_varredura.md
CONTROLADOR_VARREDURA -- requirements
Module: controlador_varredura

Interface
REQ-001 Parameter DIV, default 4: clock cycles per digit slot; legal range 2..65535.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port en  input  1  scan enable; low = display dark.
REQ-005 Port load  input  1  one-cycle strobe capturing din.
REQ-006 Port din  input  16  four BCD digits; din[3:0] = digit0 (rightmost), din[15:12] = digit3.
REQ-007 Port A, B, C, D  output  1 each  BCD nibble to the shared 7-segment decoder; A = MSB, D = LSB.
REQ-008 Port an  output  4  digit enables, active-low; an[i] drives digit i.
REQ-009 Port frame_done  output  1  one-cycle pulse at the end of each complete 4-digit frame.

Function
REQ-010 States SHALL be IDLE, DIG0, DIG1, DIG2, DIG3; state, slot counter and outputs SHALL be registered.
REQ-011 IDLE -> DIG0 when en=1; DIGn -> DIG(n+1) and DIG3 -> DIG0 after DIV cycles in the slot; any DIGn -> IDLE on the cycle after en=0.
REQ-012 Slot counter SHALL run 0..DIV-1 in each DIGn state, reset to 0 on every state change, and hold 0 in IDLE.
REQ-013 Slot cycle 0 SHALL be a guard cycle with an=4'b1111 (anti-ghosting); cycles 1..DIV-1 SHALL drive an[n]=0 and all other enables 1.
REQ-014 {A,B,C,D} SHALL equal active digit n for the whole DIGn slot, guard included; in IDLE, 4'b0000.
REQ-015 In IDLE, an SHALL be 4'b1111 and frame_done SHALL be 0.
REQ-016 frame_done SHALL be 1 only on the cycle when state=DIG3 and slot counter=DIV-1.
REQ-017 load=1 SHALL copy din into a pending register and set the pending flag; a load while pending is set overwrites the pending data.
REQ-018 Pending data SHALL transfer to the active register, and the flag SHALL clear, only on a cycle entering DIG0 (IDLE->DIG0 or DIG3->DIG0), so a frame never mixes old and new digits.
REQ-019 If load coincides with a DIG0-entry cycle, din SHALL go directly to the active register, and the pending flag SHALL end cleared.
REQ-020 An active digit value >9 SHALL blank its slot (an=4'b1111 for all DIV cycles); the nibble is still driven per REQ-014.
REQ-021 Slot timing SHALL be unaffected by load, by blanking, and by pending transfers.

Reset
REQ-022 rst=1 SHALL force the following on the next rising edge, with priority over en and load:
- state IDLE; slot counter 0;
- active and pending registers 16'h0000; pending flag 0;
- {A,B,C,D}=0; an=4'b1111; frame_done=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; no frame_done pulse; any pending load is discarded.
REQ-024 After rst deasserts with en=1, DIG0 SHALL be entered one cycle later.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN.
- Defined: digit k (k=3,2,1) SHALL be blanked (an=4'b1111 for its slot) when active digit k and every higher digit are 0. Digit0 is never blanked for this reason.
- Undefined: no zero blanking; only REQ-020 blanking applies.

Verification (DIV=4)
REQ-026 Reset, en=1, load din=16'h1234 -> first frame shows 0000; next frame digit0 slot: guard an=1111, then 3 cycles an=1110 with ABCD=0100; then 1101/0011, 1011/0010, 0111/0001; frame_done pulses once every 16 cycles.
REQ-027 Load 16'h5678 during DIG2 -> current frame completes with old digits; the following DIG0 shows ABCD=1000.
REQ-028 Load 16'h9999 on the exact DIG3->DIG0 transition cycle -> that DIG0 slot shows ABCD=1001 and the pending flag is 0.
REQ-029 Active 16'h00A5 -> digit1 slot (value 0xA) has an=1111 throughout; with LEADING_ZERO_BLANK_EN, digits 3 and 2 are also dark; without it, they are lit showing 0.
REQ-030 Assert rst during DIG2, slot 2 -> next cycle state IDLE, an=1111, ABCD=0000, no frame_done; en=0 mid-frame -> IDLE the following cycle with an=1111.
